// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS weight-update sequencer and its datapath.
package lms_pkg;

  localparam int LMS_W_W = 59;
  localparam int LMS_X_W = 16;
  localparam int LMS_E_W = 16;

  // Widest weight the saturating adder supports is SAT_MAX_W-1 bits.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef logic signed [SAT_MAX_W:0] sat_word_t;

  typedef struct packed {
    sat_word_t word;
    logic      ovf;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to a signed 'width'-bit range.
  function automatic sat_res_t sat_add(input sat_word_t w, input sat_word_t d, input int width);
    sat_word_t s;
    sat_word_t hi;
    sat_word_t lo;
    sat_res_t  r;
    s     = w + d;
    hi    = (sat_word_t'(1) <<< (width - 1)) - sat_word_t'(1);
    lo    = -hi - sat_word_t'(1);
    r.ovf = 1'b1;
    if (s > hi) begin
      r.word = hi;
    end else if (s < lo) begin
      r.word = lo;
    end else begin
      r.word = s;
      r.ovf  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lms_update_datapath.sv
// Two-stage LMS update pipeline: aligns the read address with RAM data, then
// computes sat(w + (e*x >>> MU_SHIFT)) and registers the weight-RAM write.
module lms_update_datapath
  import lms_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int W_W      = LMS_W_W,
  parameter int X_W      = LMS_X_W,
  parameter int E_W      = LMS_E_W,
  parameter int MU_SHIFT = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_p0,
  input  logic [ADDR_W-1:0]        addr_p0,
  input  logic signed [E_W-1:0]    err,
  input  logic signed [X_W-1:0]    x_rd_data,
  input  logic signed [W_W-1:0]    rd_data,
  input  logic                     clr_wr,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [W_W-1:0]    wr_data,
  output logic                     sat_hit
);

  logic                        vld_p1;
  logic [ADDR_W-1:0]           addr_p1;
  logic signed [E_W+X_W-1:0]   prod;
  logic signed [W_W:0]         delta;
  sat_res_t                    res;
  logic                        unused_hi;

  // ---- p0 -> p1: address travels with the RAM's one-cycle read latency ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= addr_p0;
  end

  assign prod  = err * x_rd_data;
  assign delta = (W_W+1)'(prod >>> MU_SHIFT);

  always_comb begin
    res = sat_add(sat_word_t'(rd_data), sat_word_t'(delta), W_W);
  end

  assign unused_hi = ^res.word[SAT_MAX_W:W_W];

  // ---- p1 -> p2: registered write port; a clear-pass zero write takes priority ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      sat_hit <= 1'b0;
    end else if (clr_wr) begin
      wr_en   <= 1'b1;
      wr_addr <= clr_addr;
      wr_data <= '0;
      sat_hit <= 1'b0;
    end else if (vld_p1) begin
      wr_en   <= 1'b1;
      wr_addr <= addr_p1;
      wr_data <= res.word[W_W-1:0];
      sat_hit <= res.ovf;
    end else begin
      wr_en   <= 1'b0;
      sat_hit <= 1'b0;
    end
  end

endmodule

// File: rtl/lms_weight_update_ctrl.sv
// Sequencer for the LMS weight RAM: one-tap-per-cycle coefficient update pass
// and a zero-fill clear pass, with busy/done handshake and a sticky saturation flag.
module lms_weight_update_ctrl
  import lms_pkg::*;
#(
  parameter int TAPS     = 512,
  parameter int ADDR_W   = 9,
  parameter int W_W      = LMS_W_W,
  parameter int X_W      = LMS_X_W,
  parameter int E_W      = LMS_E_W,
  parameter int MU_SHIFT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic signed [E_W-1:0] err,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [W_W-1:0] rd_data,
  input  logic signed [X_W-1:0] x_rd_data,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic signed [W_W-1:0] wr_data,
  output logic                  wr_en
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     rd_addr_nxt;
  logic                  rd_vld;
  logic                  rd_vld_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  err_ld;
  logic                  sat_clr;
  logic                  clr_wr;
  logic [ADDR_W-1:0]     clr_addr;
  logic signed [E_W-1:0] err_q;
  logic                  sat_hit;

  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    rd_vld_nxt  = 1'b0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_ld      = 1'b0;
    sat_clr     = 1'b0;
    clr_wr      = 1'b0;
    clr_addr    = wr_addr + ADDR_W'(1);
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          busy_nxt  = 1'b1;
          clr_wr    = 1'b1;
          clr_addr  = '0;
        end else if (start) begin
          state_nxt   = RUN;
          busy_nxt    = 1'b1;
          err_ld      = 1'b1;
          sat_clr     = 1'b1;
          rd_addr_nxt = '0;
          rd_vld_nxt  = 1'b1;
        end
      end
      CLEAR: begin
        if (wr_addr == LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          clr_wr = 1'b1;
        end
      end
      RUN: begin
        if (rd_addr == LAST) begin
          state_nxt = FLUSH;
        end else begin
          rd_addr_nxt = rd_addr + ADDR_W'(1);
          rd_vld_nxt  = 1'b1;
        end
      end
      FLUSH: begin
        // Wait for the final tap's write to be presented to the RAM.
        if (wr_en && (wr_addr == LAST)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control registers; the read address doubles as the p0 stage of the datapath ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_vld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      err_q    <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= rd_addr_nxt;
      rd_vld  <= rd_vld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (err_ld) begin
        err_q <= err;
      end
      if (sat_clr) begin
        sat_flag <= 1'b0;
      end else if (sat_hit) begin
        sat_flag <= 1'b1;
      end
    end
  end

  lms_update_datapath #(
    .ADDR_W   (ADDR_W),
    .W_W      (W_W),
    .X_W      (X_W),
    .E_W      (E_W),
    .MU_SHIFT (MU_SHIFT)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .vld_p0    (rd_vld),
    .addr_p0   (rd_addr),
    .err       (err_q),
    .x_rd_data (x_rd_data),
    .rd_data   (rd_data),
    .clr_wr    (clr_wr),
    .clr_addr  (clr_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sat_hit   (sat_hit)
  );

endmodule

// File: doc/lms_weight_update_ctrl.md
Name: lms_weight_update_ctrl

Overview:
Sequencer that drives the read and write ports of the 512x59 LMS weight simple-dual-port RAM. It performs one LMS coefficient update pass, w[k] <= sat(w[k] + ((e*x[k]) >>> MU_SHIFT)) for k = 0..TAPS-1, at one tap per cycle. It also performs a zero-fill clear pass. It sits between the adaptive-filter error path and the weight RAM; the filter datapath reads the same RAM only while this block is idle.

Parameters:
TAPS, 512, number of coefficients; must be <= 2**ADDR_W
ADDR_W, 9, RAM address width
W_W, 59, weight word width (signed two's complement)
X_W, 16, reference-sample width (signed)
E_W, 16, error width (signed)
MU_SHIFT, 12, step size mu = 2**-MU_SHIFT (arithmetic right shift of e*x)

Ports:
clk  in  1  single clock for block, weight RAM and sample buffer
rst  in  1  reset, asynchronous, active-high
start  in  1  request one update pass; sampled only in IDLE
clear  in  1  request zero-fill pass; sampled only in IDLE; priority over start
err  in  E_W  error sample; captured on the accepted start cycle
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse when a pass completes
sat_flag  out  1  sticky: any tap saturated in the last update pass
rd_addr  out  ADDR_W  read address to weight RAM and x-sample buffer
rd_data  in  W_W  weight RAM read data, valid 1 cycle after rd_addr
x_rd_data  in  X_W  x-sample buffer read data, valid 1 cycle after rd_addr
wr_addr  out  ADDR_W  weight RAM write address
wr_data  out  W_W  weight RAM write data
wr_en  out  1  weight RAM write enable

Behaviour:
- Reset values: busy=0, done=0, sat_flag=0, rd_addr=0, wr_addr=0, wr_data=0, wr_en=0; state IDLE; err register 0.
- All outputs are registered. The RAM has a 1-cycle read latency with no output register.
- FSM states: IDLE, CLEAR, RUN, FLUSH.
- IDLE:
  - clear=1 -> CLEAR.
  - else start=1 -> RUN; latch err; clear sat_flag.
  - busy rises the cycle after acceptance.
- RUN, with cycle c0 = the accept cycle:
  - rd_addr=k is driven in cycle c1+k, k=0..TAPS-1.
  - rd_data and x_rd_data for tap k are used in c2+k.
  - The write for tap k (wr_en=1, wr_addr=k) is presented in c3+k.
  - After rd_addr reaches TAPS-1 -> FLUSH until the last write retires.
- Arithmetic (pipeline stage 2):
  - p = err*x as a signed (E_W+X_W)-bit product.
  - d = p >>> MU_SHIFT (arithmetic shift), sign-extended to W_W+1 bits.
  - s = rd_data (sign-extended to W_W+1) + d.
  - If s > 2**(W_W-1)-1, write the maximum value. If s < -2**(W_W-1), write the minimum value. In either case set sat_flag. Otherwise write s[W_W-1:0].
- Completion: the last write is in c2+TAPS. In c3+TAPS: done=1 for one cycle, busy=0, state IDLE.
- A new start may be accepted in the done cycle, so a back-to-back pass has a one-cycle gap.
- CLEAR: wr_en=1, wr_data=0, wr_addr=k in cycle c1+k for k=0..TAPS-1. done pulses in cTAPS+1. sat_flag is unchanged.
- start/clear while busy: ignored, not queued.
- Hazard: each address is read once and written 2 cycles later. No address is revisited within a pass, so there is no read-after-write forwarding.
- wr_en is never asserted outside CLEAR, RUN or FLUSH write slots. rd_addr holds its last value when idle.
- Reset mid-pass: the pass aborts immediately and all outputs return to reset values. RAM contents are partially updated and undefined; the system must issue clear.
- Address counters are ADDR_W bits, terminate at TAPS-1, and never wrap past it. TAPS < 2**ADDR_W must work.

Decomposition:
- Package lms_pkg holds:
  - FSM state enum (IDLE, CLEAR, RUN, FLUSH);
  - localparams for W_W, X_W, E_W default widths;
  - a function sat_add(w, d) returning the saturated word plus an overflow bit.
- One sub-module, lms_update_datapath: the 2-stage multiply/shift/saturating-add pipeline with valid and address pass-through.
- The top holds the FSM and the counters.

Test Plan:
1. Reset, then clear with TAPS=8 -> wr_en high 8 cycles, wr_addr 0..7, wr_data=0, done in c9, busy high c1..c8.
2. Weights all 0, x[k]=k+1, err=4096, MU_SHIFT=12 -> w[k]=k+1 written in c3+k; done at c11; sat_flag=0.
3. w[3]=2**58-2, x[3]=4, err=4096 -> w[3] written as 2**58-1, sat_flag=1. Negative case: w[3]=-2**58+1, x[3]=-4 -> -2**58, sat_flag=1.
4. err=-1, x=1, MU_SHIFT=12 -> d=-1 (arithmetic shift floors), w[k] decremented by 1.
5. start pulsed at c4 during a pass; start and clear both high in IDLE -> mid-pass start ignored (one done pulse only); clear wins in IDLE.
6. rst asserted at c5 of a pass -> wr_en=0 and busy=0 asynchronously; no done pulse; next start runs the full pass correctly.
